// File: rtl/vol_flag_poller_if.sv
// Avalon-MM read-only link between the flag poller (master) and the shared flag PIO (slave).
interface vol_flag_poller_if;
  logic [1:0]  av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/vol_flag_poller.sv
// Periodic Avalon-MM poller of a 1-bit flag PIO with run-length debounce and
// single-cycle rise/fall event pulses.
module vol_flag_poller #(
  parameter int         POLL_DIV     = 1000,
  parameter int         DEBOUNCE     = 3,
  parameter int         READ_LATENCY = 1,
  parameter logic [1:0] ADDR         = 2'd0,
  parameter int         BIT_SEL      = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  vol_flag_poller_if.master        av,
  output logic                     flag,
  output logic                     flag_rise,
  output logic                     flag_fall,
  output logic [15:0]              sample_count
);

  localparam int INT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int RUN_W = $clog2(DEBOUNCE + 1);

  localparam logic [INT_W-1:0] DIV_LAST = INT_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INT_W-1:0]   intv_q, intv_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               read_q, read_d;
  logic               flag_q, flag_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [15:0]        sample_count_q, sample_count_d;
  logic               capture_s;
  logic               sample_s;

  assign sample_s      = av.av_readdata[BIT_SEL];
  assign av.av_address = ADDR;
  assign av.av_read    = read_q;
  assign flag          = flag_q;
  assign flag_rise     = rise_q;
  assign flag_fall     = fall_q;
  assign sample_count  = sample_count_q;

  // Poll sequencer: interval count in IDLE, hold request until accepted, then fixed-latency wait.
  always_comb begin
    state_d   = state_q;
    intv_d    = intv_q;
    lat_d     = lat_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          intv_d = '0;
        end else if (intv_q == DIV_LAST) begin
          state_d = ST_REQ;
          intv_d  = '0;
        end else begin
          intv_d = intv_q + INT_W'(1);
        end
      end
      ST_REQ: begin
        // enable is deliberately ignored here so a started read is never withdrawn
        if (!av.av_waitrequest) begin
          state_d = ST_WAIT;
          lat_d   = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d   = ST_IDLE;
          capture_s = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        intv_d  = '0;
        lat_d   = '0;
      end
    endcase
    read_d = (state_d == ST_REQ);
  end

  // Debounce on each captured sample; a flag change emits exactly one matching pulse.
  always_comb begin
    flag_d         = flag_q;
    run_d          = run_q;
    rise_d         = 1'b0;
    fall_d         = 1'b0;
    sample_count_d = sample_count_q;
    if (capture_s) begin
      sample_count_d = sample_count_q + 16'd1;
      if (sample_s == flag_q) begin
        run_d = '0;
      end else if (run_q == RUN_LAST) begin
        flag_d = ~flag_q;
        run_d  = '0;
        rise_d = ~flag_q;
        fall_d = flag_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      sample_count_d = sample_count_q;
    end
  end

  // State and output registers; async reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      intv_q         <= '0;
      lat_q          <= '0;
      run_q          <= '0;
      read_q         <= 1'b0;
      flag_q         <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      sample_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      intv_q         <= intv_d;
      lat_q          <= lat_d;
      run_q          <= run_d;
      read_q         <= read_d;
      flag_q         <= flag_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      sample_count_q <= sample_count_d;
    end
  end

endmodule

// File: tb/tb_vol_flag_poller.sv
// Directed bench for vol_flag_poller with POLL_DIV=4, DEBOUNCE=3, READ_LATENCY=1.
module tb_vol_flag_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        in_port;
  logic        flag;
  logic        flag_rise;
  logic        flag_fall;
  logic [15:0] sample_count;

  int n_tests = 0;
  int n_fail  = 0;

  vol_flag_poller_if av_if ();

  vol_flag_poller #(
    .POLL_DIV     (4),
    .DEBOUNCE     (3),
    .READ_LATENCY (1),
    .ADDR         (2'd0),
    .BIT_SEL      (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .av           (av_if.master),
    .flag         (flag),
    .flag_rise    (flag_rise),
    .flag_fall    (flag_fall),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  // Flag PIO slave: readdata registered every cycle from the bench-driven input pin.
  always @(posedge clk) av_if.av_readdata <= {31'd0, in_port};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count falling edges until av_read is seen high (bounded).
  task automatic wait_read(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (av_if.av_read !== 1'b1 && cyc < 40);
  endtask

  // One full poll with the pin at v; returns outputs seen the cycle after capture.
  task automatic poll(input logic v, input int exp_wait,
                      output logic f, output logic r, output logic fl);
    int c;
    in_port = v;
    wait_read(c);
    chk_eq("poll_req_delay", c, exp_wait);
    @(negedge clk);
    @(negedge clk);
    f  = flag;
    r  = flag_rise;
    fl = flag_fall;
  endtask

  int   c;
  int   stable;
  int   seen;
  logic f, r, fl;
  logic any_s;
  logic seq_s [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    in_port = 1'b0;
    av_if.av_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_av_read", av_if.av_read, 1'b0);
    chk_eq("rst_av_address", av_if.av_address, 2'd0);
    chk_eq("rst_flag", flag, 1'b0);
    chk_eq("rst_rise", flag_rise, 1'b0);
    chk_eq("rst_fall", flag_fall, 1'b0);
    chk_eq("rst_count", sample_count, 16'd0);

    // 1: first poll timing and period
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_read(c);
    chk_eq("t1_first_read_delay", c, 4);
    @(negedge clk);
    chk_eq("t1_read_one_cycle", av_if.av_read, 1'b0);
    chk_eq("t1_count_pending", sample_count, 16'd0);
    @(negedge clk);
    chk_eq("t1_count_after", sample_count, 16'd1);
    wait_read(c);
    chk_eq("t1_period", c + 2, 6);
    @(negedge clk);
    @(negedge clk);
    chk_eq("t1_count_second", sample_count, 16'd2);

    // 2: clean rise, then clean fall
    poll(1'b1, 4, f, r, fl);
    chk_eq("t2_s1_flag", f, 1'b0);
    poll(1'b1, 4, f, r, fl);
    chk_eq("t2_s2_flag", f, 1'b0);
    chk_eq("t2_s2_rise", r, 1'b0);
    poll(1'b1, 4, f, r, fl);
    chk_eq("t2_s3_flag", f, 1'b1);
    chk_eq("t2_s3_rise", r, 1'b1);
    chk_eq("t2_s3_fall", fl, 1'b0);
    chk_eq("t2_count", sample_count, 16'd5);
    @(negedge clk);
    chk_eq("t2_rise_one_cycle", flag_rise, 1'b0);
    chk_eq("t2_flag_held", flag, 1'b1);
    poll(1'b0, 3, f, r, fl);
    chk_eq("t2_f1_flag", f, 1'b1);
    poll(1'b0, 4, f, r, fl);
    chk_eq("t2_f2_flag", f, 1'b1);
    poll(1'b0, 4, f, r, fl);
    chk_eq("t2_f3_flag", f, 1'b0);
    chk_eq("t2_f3_fall", fl, 1'b1);
    chk_eq("t2_f3_rise", r, 1'b0);

    // 3: glitch rejection 1,1,0,1,1 then a third consecutive 1
    any_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      poll(seq_s[i], 4, f, r, fl);
      any_s = any_s | f | r | fl;
    end
    chk_eq("t3_glitch_quiet", any_s, 1'b0);
    poll(1'b1, 4, f, r, fl);
    chk_eq("t3_flag_up", f, 1'b1);
    chk_eq("t3_rise", r, 1'b1);
    chk_eq("t3_count", sample_count, 16'd14);

    // 4: five stall cycles at REQ
    av_if.av_waitrequest = 1'b1;
    wait_read(c);
    chk_eq("t4_req_delay", c, 4);
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      if (av_if.av_read === 1'b1 && av_if.av_address === 2'd0) stable++;
      if (i < 5) @(negedge clk);
    end
    av_if.av_waitrequest = 1'b0;
    chk_eq("t4_req_stable", stable, 6);
    @(negedge clk);
    chk_eq("t4_read_dropped", av_if.av_read, 1'b0);
    chk_eq("t4_count_pending", sample_count, 16'd14);
    @(negedge clk);
    chk_eq("t4_count_after", sample_count, 16'd15);
    chk_eq("t4_flag", flag, 1'b1);
    wait_read(c);
    chk_eq("t4_period", c + 7, 11);

    // 5: enable dropped while in REQ
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_eq("t5_count", sample_count, 16'd16);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (av_if.av_read === 1'b1) seen++;
    end
    chk_eq("t5_no_read", seen, 0);
    enable = 1'b1;
    wait_read(c);
    chk_eq("t5_reenable_delay", c, 4);
    @(negedge clk);
    @(negedge clk);
    chk_eq("t5_count_after", sample_count, 16'd17);

    // 6: async reset during WAIT with flag=1
    chk_eq("t6_flag_before", flag, 1'b1);
    wait_read(c);
    chk_eq("t6_req_delay", c, 4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_eq("t6_rst_read", av_if.av_read, 1'b0);
    chk_eq("t6_rst_flag", flag, 1'b0);
    chk_eq("t6_rst_fall", flag_fall, 1'b0);
    chk_eq("t6_rst_count", sample_count, 16'd0);
    any_s = 1'b0;
    repeat (2) begin
      @(negedge clk);
      any_s = any_s | flag_fall | av_if.av_read;
    end
    chk_eq("t6_rst_quiet", any_s, 1'b0);
    reset_n = 1'b1;
    in_port = 1'b0;
    wait_read(c);
    chk_eq("t6_restart_delay", c, 4);
    @(negedge clk);
    @(negedge clk);
    chk_eq("t6_count_restart", sample_count, 16'd1);

    // sample_count wrap from a preloaded 0xFFFF
    force dut.sample_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.sample_count_q;
    chk_eq("t6_preload", sample_count, 16'hFFFF);
    poll(1'b0, 3, f, r, fl);
    chk_eq("t6_wrap", sample_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
